// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor: D = A - B (mod 2^WIDTH), one bit
//   per clock, LSB first. Two half-subtractor cells plus a single borrow flop
//   replace a borrow chain. A START/DONE handshake allows back-to-back issue.
//
// Parameters
//   WIDTH  operand/result width in bits (2..32)
//
// Ports
//   CLK    rising-edge clock
//   RST    synchronous active-low reset
//   START  request; accepted only in IDLE or DONE state
//   A      minuend, captured on the accepting edge
//   B      subtrahend, captured on the accepting edge
//   BUSY   high while bits are being processed
//   DONE   one-cycle completion pulse; D/BOUT/ZERO valid from this cycle on
//   D      difference A - B
//   BOUT   final borrow (A < B unsigned)
//   ZERO   D == 0
// ----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             ZERO
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb, sd;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             hs1_d, hs1_b;
  logic             hs2_d, hs2_b;
  logic             br_next;
  logic [WIDTH-1:0] sd_next;

  // Half-subtractor cells, next-state decode and handshake qualification.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;

    // Cell 1: a - b
    hs1_d   = sa[0] ^ sb[0];
    hs1_b   = ~sa[0] & sb[0];
    // Cell 2: (a - b) - borrow_in
    hs2_d   = hs1_d ^ br;
    hs2_b   = ~hs1_d & br;
    br_next = hs1_b | hs2_b;

    // Result enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
    sd_next = {hs2_d, sd[WIDTH-1:1]};

    case (state)
      ST_IDLE: begin
        if (START) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (START) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; BUSY/DONE are registered from the next state so that they
  // are flop outputs aligned with the state they describe.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_next;
      BUSY  <= (state_next == ST_SHIFT);
      DONE  <= (state_next == ST_DONE);
    end
  end

  // Datapath: operand shift registers, borrow flop, bit counter, results.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      BOUT <= 1'b0;
      ZERO <= 1'b0;
    end else if (accept) begin
      sa  <= A;
      sb  <= B;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == ST_SHIFT) begin
      sa <= {1'b0, sa[WIDTH-1:1]};
      sb <= {1'b0, sb[WIDTH-1:1]};
      sd <= sd_next;
      br <= br_next;
      if (last) begin
        D    <= sd_next;
        BOUT <= br_next;
        ZERO <= (sd_next == '0);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST = 1'b0;

  // WIDTH = 8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, zero8;
  logic [7:0] d8;

  // WIDTH = 2 instance
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, bout2, zero2;
  logic [1:0] d2;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .START(start8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .D(d8), .BOUT(bout8), .ZERO(zero8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .START(start2), .A(a2), .B(b2),
    .BUSY(busy2), .DONE(done2), .D(d2), .BOUT(bout2), .ZERO(zero2)
  );

  typedef struct {
    logic [7:0] d;
    logic       bout;
    logic       zero;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_seen8 = 0;
  int unsigned done_seen2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitors: pop expected results whenever a DONE pulse is presented.
  always @(negedge CLK) begin
    if (RST) begin
      check("busy8_and_done8_exclusive", {31'b0, busy8 & done8}, 32'd0);
      if (done8) begin
        done_seen8++;
        if (q8.size() == 0) begin
          check("unexpected_done8", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          check("d8",    {24'b0, d8},    {24'b0, e.d});
          check("bout8", {31'b0, bout8}, {31'b0, e.bout});
          check("zero8", {31'b0, zero8}, {31'b0, e.zero});
        end
      end
      if (done2) begin
        done_seen2++;
        if (q2.size() == 0) begin
          check("unexpected_done2", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q2.pop_front();
          check("d2",    {30'b0, d2},    {24'b0, e.d});
          check("bout2", {31'b0, bout2}, {31'b0, e.bout});
          check("zero2", {31'b0, zero2}, {31'b0, e.zero});
        end
      end
    end
  end

  // Single WIDTH=8 operation with latency and BUSY-duration checks.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eb, input logic ez);
    int unsigned lat, bcnt;
    exp_t e;
    e.d = ed; e.bout = eb; e.zero = ez;
    q8.push_back(e);
    a8 = a; b8 = b; start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      step();
      lat++;
    end
    check("latency8", lat, 32'd8);
    check("busy_cycles8", bcnt, 32'd8);
    step();
    check("done8_one_cycle", {31'b0, done8}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned cnt, ds;
    exp_t e;

    // Reset for two cycles
    RST = 1'b0;
    step();
    step();
    check("rst_busy", {31'b0, busy8}, 32'd0);
    check("rst_done", {31'b0, done8}, 32'd0);
    check("rst_d",    {24'b0, d8},    32'd0);
    check("rst_bout", {31'b0, bout8}, 32'd0);
    check("rst_zero", {31'b0, zero8}, 32'd0);
    RST = 1'b1;
    step();

    // Basic, negative, equal
    run8(8'd200, 8'd55, 8'h91, 1'b0, 1'b0);
    run8(8'd5,   8'd10, 8'hFB, 1'b1, 1'b0);
    run8(8'hA5,  8'hA5, 8'h00, 1'b0, 1'b1);
    check("zero_held", {31'b0, zero8}, 32'd1);

    // START ignored while busy
    ds = done_seen8;
    e.d = 8'h0F; e.bout = 1'b0; e.zero = 1'b0;
    q8.push_back(e);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 25; i++) step();
    check("ignored_start_one_done", done_seen8 - ds, 32'd1);
    check("ignored_start_d_held", {24'b0, d8}, 32'h0F);

    // Reset mid-operation: RST low is sampled on the 4th SHIFT edge
    ds = done_seen8;
    a8 = 8'd200; b8 = 8'd55; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    check("mid_busy_before_rst", {31'b0, busy8}, 32'd1);
    RST = 1'b0;
    step();
    check("mid_rst_busy", {31'b0, busy8}, 32'd0);
    check("mid_rst_done", {31'b0, done8}, 32'd0);
    check("mid_rst_d",    {24'b0, d8},    32'd0);
    check("mid_rst_bout", {31'b0, bout8}, 32'd0);
    check("mid_rst_zero", {31'b0, zero8}, 32'd0);
    RST = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("mid_rst_no_done", done_seen8 - ds, 32'd0);

    // Back-to-back, WIDTH=8: 0x00-0xFF then 0xFF-0x00
    e.d = 8'h01; e.bout = 1'b1; e.zero = 1'b0;
    q8.push_back(e);
    e.d = 8'hFF; e.bout = 1'b0; e.zero = 1'b0;
    q8.push_back(e);
    a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
    step();
    a8 = 8'hFF; b8 = 8'h00;
    cnt = 0;
    while (!done8 && cnt < 40) begin step(); cnt++; end
    check("b2b8_first_latency", cnt, 32'd8);
    step();
    start8 = 1'b0;
    check("b2b8_accept_busy", {31'b0, busy8}, 32'd1);
    cnt = 1;
    while (!done8 && cnt < 40) begin step(); cnt++; end
    check("b2b8_interval", cnt, 32'd9);
    step();
    step();

    // Back-to-back, WIDTH=2: 0-3 then 3-0
    e.d = 8'h01; e.bout = 1'b1; e.zero = 1'b0;
    q2.push_back(e);
    e.d = 8'h03; e.bout = 1'b0; e.zero = 1'b0;
    q2.push_back(e);
    a2 = 2'd0; b2 = 2'd3; start2 = 1'b1;
    step();
    a2 = 2'd3; b2 = 2'd0;
    cnt = 0;
    while (!done2 && cnt < 20) begin step(); cnt++; end
    check("b2b2_first_latency", cnt, 32'd2);
    step();
    start2 = 1'b0;
    cnt = 1;
    while (!done2 && cnt < 20) begin step(); cnt++; end
    check("b2b2_interval", cnt, 32'd3);
    for (int i = 0; i < 5; i++) step();

    check("q8_drained", q8.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);
    check("done2_count", done_seen2, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
